// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared defaults and depth helper for the 2R1W register file
package reg_file_pkg;

  localparam int REG_FILE_N_DEF = 8;
  localparam int REG_FILE_W_DEF = 2;

  function automatic int depth(input int w);
    return 1 << w;
  endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// rtl/reg_file_rd_port.sv - registered read port with optional write forwarding
// Forwarding from the write port is compiled in only when REG_FILE_BYPASS_EN is defined.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int N       = REG_FILE_N_DEF,
  parameter int W       = REG_FILE_W_DEF,
  parameter bit ZERO_R0 = 1'b0,
  localparam int DEPTH  = depth(W)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               rd_en,
  input  logic [W-1:0]       r_addr,
  input  logic [DEPTH*N-1:0] mem_flat,
  input  logic               wr_acc,
  input  logic [W-1:0]       w_addr,
  input  logic [N-1:0]       w_data,
  output logic [N-1:0]       r_data,
  output logic               r_valid
);

  logic [N-1:0] sel_data;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_addr == W'(i)) sel_data = mem_flat[i*N +: N];
    end
`ifdef REG_FILE_BYPASS_EN
    if (wr_acc && (w_addr == r_addr)) sel_data = w_data;
`endif
    // Hardwired zero wins over both storage and forwarding.
    if (ZERO_R0 && (r_addr == '0)) sel_data = '0;
  end

`ifndef REG_FILE_BYPASS_EN
  logic unused_fwd;
  assign unused_fwd = ^{wr_acc, w_addr, w_data};
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= rd_en;
      if (rd_en) r_data <= sel_data;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - parametrised 2-read/1-write register file with written bitmap
// Define REG_FILE_BYPASS_EN to forward same-edge writes to reads of the same address.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int N       = REG_FILE_N_DEF,
  parameter int W       = REG_FILE_W_DEF,
  parameter bit ZERO_R0 = 1'b0,
  localparam int DEPTH  = depth(W)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [W-1:0]     w_addr,
  input  logic [N-1:0]     w_data,
  input  logic             rd_en_a,
  input  logic [W-1:0]     r_addr_a,
  output logic [N-1:0]     r_data_a,
  output logic             r_valid_a,
  input  logic             rd_en_b,
  input  logic [W-1:0]     r_addr_b,
  output logic [N-1:0]     r_data_b,
  output logic             r_valid_b,
  output logic [DEPTH-1:0] written
);

  logic [N-1:0]       mem [DEPTH];
  logic [DEPTH*N-1:0] mem_flat;
  logic               wr_acc;

  // Writes to a hardwired-zero entry 0 are dropped entirely, bitmap included.
  assign wr_acc = wr_en && !(ZERO_R0 && (w_addr == '0));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      written <= '0;
    end else if (wr_acc) begin
      mem[w_addr]     <= w_data;
      written[w_addr] <= 1'b1;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*N +: N] = mem[g];
  end

  reg_file_rd_port #(.N(N), .W(W), .ZERO_R0(ZERO_R0)) u_rd_a (
    .clk      (clk),
    .clr      (clr),
    .rd_en    (rd_en_a),
    .r_addr   (r_addr_a),
    .mem_flat (mem_flat),
    .wr_acc   (wr_acc),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .r_data   (r_data_a),
    .r_valid  (r_valid_a)
  );

  reg_file_rd_port #(.N(N), .W(W), .ZERO_R0(ZERO_R0)) u_rd_b (
    .clk      (clk),
    .clr      (clr),
    .rd_en    (rd_en_b),
    .r_addr   (r_addr_b),
    .mem_flat (mem_flat),
    .wr_acc   (wr_acc),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .r_data   (r_data_b),
    .r_valid  (r_valid_b)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb/tb_reg_file_2r1w.sv - bench for reg_file_2r1w (default, ZERO_R0=1 and N=32/W=4 instances)
module tb_reg_file_2r1w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic        wr_en_s [3];
  logic        rd_en_a_s [3];
  logic        rd_en_b_s [3];
  logic [3:0]  w_addr_s [3];
  logic [3:0]  r_addr_a_s [3];
  logic [3:0]  r_addr_b_s [3];
  logic [31:0] w_data_s [3];

  logic [7:0]  ra0, rb0, ra1, rb1;
  logic [31:0] ra2, rb2;
  logic        va0, vb0, va1, vb1, va2, vb2;
  logic [3:0]  wr0, wr1;
  logic [15:0] wr2;

  logic [31:0] act_a [3];
  logic [31:0] act_b [3];
  logic        act_va [3];
  logic        act_vb [3];
  logic [15:0] act_wr [3];

  assign act_a[0] = {24'b0, ra0};
  assign act_a[1] = {24'b0, ra1};
  assign act_a[2] = ra2;
  assign act_b[0] = {24'b0, rb0};
  assign act_b[1] = {24'b0, rb1};
  assign act_b[2] = rb2;
  assign act_va[0] = va0;
  assign act_va[1] = va1;
  assign act_va[2] = va2;
  assign act_vb[0] = vb0;
  assign act_vb[1] = vb1;
  assign act_vb[2] = vb2;
  assign act_wr[0] = {12'b0, wr0};
  assign act_wr[1] = {12'b0, wr1};
  assign act_wr[2] = wr2;

  reg_file_2r1w dut0 (
    .clk(clk), .clr(clr), .wr_en(wr_en_s[0]), .w_addr(w_addr_s[0][1:0]), .w_data(w_data_s[0][7:0]),
    .rd_en_a(rd_en_a_s[0]), .r_addr_a(r_addr_a_s[0][1:0]), .r_data_a(ra0), .r_valid_a(va0),
    .rd_en_b(rd_en_b_s[0]), .r_addr_b(r_addr_b_s[0][1:0]), .r_data_b(rb0), .r_valid_b(vb0),
    .written(wr0)
  );

  reg_file_2r1w #(.ZERO_R0(1'b1)) dut1 (
    .clk(clk), .clr(clr), .wr_en(wr_en_s[1]), .w_addr(w_addr_s[1][1:0]), .w_data(w_data_s[1][7:0]),
    .rd_en_a(rd_en_a_s[1]), .r_addr_a(r_addr_a_s[1][1:0]), .r_data_a(ra1), .r_valid_a(va1),
    .rd_en_b(rd_en_b_s[1]), .r_addr_b(r_addr_b_s[1][1:0]), .r_data_b(rb1), .r_valid_b(vb1),
    .written(wr1)
  );

  reg_file_2r1w #(.N(32), .W(4)) dut2 (
    .clk(clk), .clr(clr), .wr_en(wr_en_s[2]), .w_addr(w_addr_s[2]), .w_data(w_data_s[2]),
    .rd_en_a(rd_en_a_s[2]), .r_addr_a(r_addr_a_s[2]), .r_data_a(ra2), .r_valid_a(va2),
    .rd_en_b(rd_en_b_s[2]), .r_addr_b(r_addr_b_s[2]), .r_data_b(rb2), .r_valid_b(vb2),
    .written(wr2)
  );

  int checks = 0;
  int failures = 0;

  function automatic bit zr0(int k);
    return k == 1;
  endfunction

  function automatic int depth_of(int k);
    return (k == 2) ? 16 : 4;
  endfunction

  function automatic logic [31:0] dmask(int k);
    return (k == 2) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%h required=%h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Reference model: plain array per instance plus expected port state.
  logic [31:0] mem_m [3][16];
  logic [31:0] exp_a [3];
  logic [31:0] exp_b [3];
  logic        exp_va [3];
  logic        exp_vb [3];
  logic [15:0] exp_wr [3];

  function automatic bit write_ok(int k);
    return wr_en_s[k] && !(zr0(k) && w_addr_s[k] == 4'd0);
  endfunction

  function automatic logic [31:0] exp_read(int k, logic [3:0] a);
    if (zr0(k) && a == 4'd0) return 32'd0;
`ifdef REG_FILE_BYPASS_EN
    if (write_ok(k) && w_addr_s[k] == a) return w_data_s[k] & dmask(k);
`endif
    return mem_m[k][a];
  endfunction

  always @(posedge clk or posedge clr) begin
    for (int k = 0; k < 3; k++) begin
      if (clr) begin
        for (int j = 0; j < 16; j++) mem_m[k][j] <= 32'd0;
        exp_a[k]  <= 32'd0;
        exp_b[k]  <= 32'd0;
        exp_va[k] <= 1'b0;
        exp_vb[k] <= 1'b0;
        exp_wr[k] <= 16'd0;
      end else begin
        exp_va[k] <= rd_en_a_s[k];
        exp_vb[k] <= rd_en_b_s[k];
        if (rd_en_a_s[k]) exp_a[k] <= exp_read(k, r_addr_a_s[k]);
        if (rd_en_b_s[k]) exp_b[k] <= exp_read(k, r_addr_b_s[k]);
        if (write_ok(k)) begin
          mem_m[k][w_addr_s[k]]  <= w_data_s[k] & dmask(k);
          exp_wr[k][w_addr_s[k]] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("r_data_a", k, act_a[k], exp_a[k]);
      chk("r_data_b", k, act_b[k], exp_b[k]);
      chk("r_valid_a", k, {31'b0, act_va[k]}, {31'b0, exp_va[k]});
      chk("r_valid_b", k, {31'b0, act_vb[k]}, {31'b0, exp_vb[k]});
      chk("written", k, {16'b0, act_wr[k]}, {16'b0, exp_wr[k]});
    end
  end

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      wr_en_s[k]   = 1'b0;
      rd_en_a_s[k] = 1'b0;
      rd_en_b_s[k] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int k, logic [3:0] a, logic [31:0] d);
    wr_en_s[k]  = 1'b1;
    w_addr_s[k] = a;
    w_data_s[k] = d;
  endtask

  task automatic rda(int k, logic [3:0] a);
    rd_en_a_s[k]  = 1'b1;
    r_addr_a_s[k] = a;
  endtask

  task automatic rdb(int k, logic [3:0] a);
    rd_en_b_s[k]  = 1'b1;
    r_addr_b_s[k] = a;
  endtask

  logic [31:0] rdw_exp;

  initial begin
    clr = 1'b1;
    idle();
    for (int k = 0; k < 3; k++) begin
      w_addr_s[k] = '0; w_data_s[k] = '0; r_addr_a_s[k] = '0; r_addr_b_s[k] = '0;
    end
    step(); step();
    clr = 1'b0;

    rda(0, 0); rdb(0, 3); step();
    chk("rst_ra", 0, act_a[0], 32'h00);
    chk("rst_rb", 0, act_b[0], 32'h00);
    chk("rst_written", 0, {16'b0, act_wr[0]}, 32'h0);

    idle(); wr(0, 2, 32'hBB); step();
    idle(); wr(0, 3, 32'hF0); step();
    idle(); rda(0, 2); rdb(0, 3); step();
    chk("dual_ra", 0, act_a[0], 32'hBB);
    chk("dual_rb", 0, act_b[0], 32'hF0);
    chk("dual_va", 0, {31'b0, act_va[0]}, 32'd1);
    chk("dual_vb", 0, {31'b0, act_vb[0]}, 32'd1);
    chk("dual_written", 0, {16'b0, act_wr[0]}, 32'hC);
    chk("model_dual_ra", 0, exp_a[0], 32'hBB);

`ifdef REG_FILE_BYPASS_EN
    rdw_exp = 32'h5A;
`else
    rdw_exp = 32'h11;
`endif
    idle(); wr(0, 1, 32'h11); step();
    idle(); wr(0, 1, 32'h5A); rda(0, 1); step();
    chk("rdw_ra", 0, act_a[0], rdw_exp);
    chk("model_rdw_ra", 0, exp_a[0], rdw_exp);
    idle(); rda(0, 1); step();
    chk("rdw_next_ra", 0, act_a[0], 32'h5A);

    idle(); rda(0, 2); step();
    chk("hold_pre_ra", 0, act_a[0], 32'hBB);
    idle();
    for (int i = 0; i < 3; i++) begin
      wr(0, 2, 32'h00); step();
      chk("hold_ra", 0, act_a[0], 32'hBB);
      chk("hold_va", 0, {31'b0, act_va[0]}, 32'd0);
    end

    idle(); wr(1, 0, 32'hFF); rda(1, 0); rdb(1, 0); step();
    chk("zr0_ra_wedge", 1, act_a[1], 32'h00);
    chk("zr0_rb_wedge", 1, act_b[1], 32'h00);
    idle(); rda(1, 0); rdb(1, 0); step();
    chk("zr0_ra", 1, act_a[1], 32'h00);
    chk("zr0_rb", 1, act_b[1], 32'h00);
    chk("zr0_written", 1, {16'b0, act_wr[1]}, 32'h0);

    idle(); wr(2, 15, 32'hDEADBEEF); step();
    idle(); wr(2, 0, 32'h12345678); step();
    idle(); rda(2, 15); rdb(2, 0); step();
    chk("wide_ra", 2, act_a[2], 32'hDEADBEEF);
    chk("wide_rb", 2, act_b[2], 32'h12345678);
    chk("wide_written", 2, {16'b0, act_wr[2]}, 32'h8001);

    idle(); #2;
    clr = 1'b1;
    #1;
    chk("midclr_ra", 0, act_a[0], 32'h0);
    chk("midclr_written", 0, {16'b0, act_wr[0]}, 32'h0);
    chk("midclr_ra_wide", 2, act_a[2], 32'h0);
    chk("midclr_written_wide", 2, {16'b0, act_wr[2]}, 32'h0);
    step(); step();
    clr = 1'b0;

    repeat (600) begin
      for (int k = 0; k < 3; k++) begin
        wr_en_s[k]   = ($urandom_range(0, 1) == 1);
        w_addr_s[k]  = 4'($urandom_range(0, depth_of(k) - 1));
        w_data_s[k]  = $urandom & dmask(k);
        rd_en_a_s[k] = ($urandom_range(0, 3) != 0);
        rd_en_b_s[k] = ($urandom_range(0, 3) != 0);
        r_addr_a_s[k] = ($urandom_range(0, 2) == 0) ? w_addr_s[k]
                                                    : 4'($urandom_range(0, depth_of(k) - 1));
        r_addr_b_s[k] = ($urandom_range(0, 2) == 0) ? r_addr_a_s[k]
                                                    : 4'($urandom_range(0, depth_of(k) - 1));
      end
      clr = ($urandom_range(0, 63) == 0);
      step();
    end
    clr = 1'b0;
    idle(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Parametrised register file with one write port and two independent registered read ports, plus an entry-written bitmap. Successor to the single-port 8×4 register file: width, depth and the hardwired-zero entry 0 are configurable, and read-during-write behaviour is explicitly defined. It sits between the datapath's result bus and its two operand buses.

## Interface
- `N`, default 8: data width in bits.
- `W`, default 2: address width in bits; depth `DEPTH = 2**W` (derived, not overridable).
- `ZERO_R0`, default 0: when 1, entry 0 is hardwired to zero.

- `clk`  in  1  rising-edge clock.
- `clr`  in  1  reset; one clock, asynchronous and active-high.
- `wr_en`  in  1  write strobe.
- `w_addr`  in  W  write address.
- `w_data`  in  N  write data.
- `rd_en_a`  in  1  read request, port A.
- `r_addr_a`  in  W  read address, port A.
- `r_data_a`  out  N  registered read data, port A.
- `r_valid_a`  out  1  `r_data_a` holds data from a read accepted on the previous edge.
- `rd_en_b`, `r_addr_b`, `r_data_b`, `r_valid_b`: same as port A, for port B.
- `written`  out  DEPTH  bit i is set once entry i has been written since reset.

## Operation
- **Write.** On a rising edge with `wr_en`=1, store `w_data` at `w_addr` and set `written[w_addr]`.
  - When `ZERO_R0`=1 and `w_addr`=0, the write is dropped and `written[0]` stays 0.
- **Read.** On a rising edge with `rd_en_x`=1:
  - `r_data_x` ← entry at `r_addr_x`, or 0 when `ZERO_R0`=1 and the address is 0.
  - `r_valid_x` ← 1.
- **Idle read port.** On an edge with `rd_en_x`=0, `r_data_x` holds its value and `r_valid_x` ← 0.
- **Independent ports.** Ports A and B are fully independent and may read the same address on the same edge.
- **Read-during-write, same address, same edge.** Result is set by the configuration macro (see Configuration).
- **Reset.** `clr`=1 asynchronously clears all entries, `r_data_a/b`, `r_valid_a/b` and `written` to 0. They stay cleared for as long as `clr` is high; writes and reads are ignored.
- **Arithmetic.** Addresses are unsigned with no wrap logic; every W-bit value is a valid entry.

## Timing
- Write latency: a value written on edge k is readable by a read issued on edge k+1. The data appears on `r_data` after edge k+1.
- Read latency: one cycle, address sampled at edge k, data valid after edge k.
- `written` updates on the same edge as the write.
- `clr` deasserting between edges: the first functional edge is the first rising edge with `clr`=0.
- `clr` asserting mid-cycle clears outputs immediately, with no edge required.

## Configuration
- `REG_FILE_BYPASS_EN` defined: a read and a write to the same address on the same edge return the new `w_data`. Write-to-read forwarding is enabled. When `ZERO_R0`=1 and the address is 0, the read still returns 0.
- `REG_FILE_BYPASS_EN` undefined: the same case returns the old stored value, with no forwarding path.

## Structure
- Shared package `reg_file_pkg` holds:
  - default constants `REG_FILE_N_DEF=8` and `REG_FILE_W_DEF=2`;
  - the `DEPTH` helper function (2**W).
- Natural sub-module: `reg_file_rd_port`, instantiated twice. It holds the read mux, the bypass compare and the output/valid registers, and takes the storage array as a flattened bus.

## Test plan
Defaults N=8, W=2, `ZERO_R0`=0 unless stated.
1. **Reset.** Hold `clr`=1 for 2 cycles, then read A=0, B=3 → `r_data_a`=`r_data_b`=0x00, `written`=4'b0000. Assert `clr` mid-cycle after writes → all outputs 0 before the next edge.
2. **Write then dual read.**
   - Write 0xBB@2, then 0xF0@3.
   - Next edge, read A=2, B=3 → `r_data_a`=0xBB, `r_data_b`=0xF0, both valid=1, `written`=4'b1100.
3. **Read-during-write.** Entry 1 holds 0x11. On one edge, write 0x5A@1 and read A=1.
   - With `REG_FILE_BYPASS_EN` → `r_data_a`=0x5A.
   - Without it → `r_data_a`=0x11.
   - Either way, the next read returns 0x5A.
4. **Hold on idle.** After a read returning 0xBB, drop `rd_en_a` for 3 cycles while writing 0x00@2 → `r_data_a` stays 0xBB and `r_valid_a`=0.
5. **ZERO_R0=1.** Write 0xFF@0, then read A=0 and B=0 (also on the write edge with bypass) → both return 0x00 and `written[0]`=0.
6. **Wider config, N=32, W=4.**
   - Write 0xDEADBEEF@15 and 0x12345678@0, then read both → exact values returned.
   - `written`=16'h8001.
